mc_cpu32: RTL and testbench
===========================

# mc_cpu32

Multicycle 32-bit CPU core: instruction decode, 16×32 register file, ALU, byte-addressed data memory, and a fixed six-state sequencer. Each instruction retires in exactly 6 clocks. Instruction memory is external and read combinationally. The core is the top-level compute block; the bench drives program images and observes architectural state through a debug port.

## Interface
- `PC_W`, default 12: byte-address width of the PC and instruction space (4096 B).
- `DMEM_AW`, default 12: byte-address width of the internal data memory (4096 B).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `imem_addr`, out, `PC_W`: current PC (byte address, low 2 bits always 0).
- `imem_rdata`, in, 32: combinational instruction word at `imem_addr`. The byte at the lowest address is bits [31:24] (big-endian).
- `halted`, out, 1: set when a HALT instruction retires; sticky until reset.
- `retire`, out, 1: one-cycle pulse in the S_PC cycle of every instruction, including HALT.
- `dbg_sel`, in, 4: register index for debug read.
- `dbg_data`, out, 32: combinational value of `R[dbg_sel]`.

## Operation
Instruction fields:
- op = [31:26]
- rd = [25:22]
- rs1 = [21:18]
- rs2 = [17:14]
- imm = [13:0], sign-extended to 32 bits

Register and ALU rules:
- R0 always reads 0; writes to R0 are discarded.
- Arithmetic wraps mod 2^32. Shift amount is the low 5 bits of the second operand.
- SLT is a signed compare; SLTU is unsigned. Both produce 0 or 1.

Register-register ops (second operand is `R[rs2]`), opcodes 0x00–0x09: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
- Immediate forms: opcode + 0x10 (0x10–0x19), same order, second operand is imm.

Memory ops:
- 0x20 LW: `rd = M32[R[rs1]+imm]`.
- 0x22 SW: `M32[R[rs1]+imm] = R[rs2]`.
- Word accesses force address bits [1:0] to 0.
- Addresses wrap modulo 2^`DMEM_AW`.
- Memory is big-endian, matching the instruction format.

Control flow:
- 0x30 BEQ: if `R[rs1]==R[rs2]`, `pc = imm`.
- 0x31 BNE: if `R[rs1]!=R[rs2]`, `pc = imm`.
- 0x32 JAL: `rd = pc+4`, then `pc = R[rs1]+imm`.
- All PC targets are truncated to `PC_W` with bits [1:0] forced to 0.
- 0x3F HALT.
- Any other opcode executes as NOP (PC advances by 4).

## Timing
Sequencer states, one clock each, in order S_FETCH → S_DECODE → S_EXEC → S_MEM → S_WB → S_PC → S_FETCH:
- S_FETCH: latch `imem_rdata` into the instruction register.
- S_DECODE: decode fields and latch `R[rs1]`, `R[rs2]`.
- S_EXEC: latch the ALU result and the branch condition.
- S_MEM: store writes memory; load reads and latches its data.
- S_WB: register write, if the instruction has one.
- S_PC: update PC (target or pc+4, wrapping mod 2^`PC_W`) and pulse `retire`.

HALT and sequencing:
- On HALT, `halted` rises together with `retire` in S_PC. After that the PC and state freeze, no further register or memory writes occur, and `retire` stays 0.
- A store's data is visible to a load in the next instruction.
- A register written in S_WB is visible to the next instruction's S_DECODE.
- Writing rs1 as rd in JAL uses the old `R[rs1]` for the target.

Reset (any cycle, including mid-instruction):
- Aborts the current instruction with no partial writeback.
- Sets `pc=0`, state = S_FETCH, `halted=0`, `retire=0`, and all registers to 0.
- Data memory contents are not cleared. They are X after power-up.

## Configuration
- `MC_CPU32_BYTE_ACCESS_EN` defined: the core also implements
  - 0x21 LB: loads `M8[R[rs1]+imm]` sign-extended into rd.
  - 0x23 SB: writes `R[rs2][7:0]` to `M8[R[rs1]+imm]`, leaving the other bytes of the word unchanged. Byte accesses use the full byte address.
- Undefined: 0x21 and 0x23 execute as NOP.

## Test plan
- Reset: hold `rst` for 2 clocks mid-instruction, then release → `imem_addr=0`, `halted=0`, every `dbg_data` = 0; first `retire` pulse exactly 6 clocks after release.
- ALU: ADDI R1,R0,-3; ADDI R2,R0,5; SUB R3,R1,R2; SRA R4,R1,1; SLTU R5,R1,R2 → R3=0xFFFFFFF8, R4=0xFFFFFFFE, R5=0; `retire` spaced every 6 clocks.
- Memory: R1=0x12345678; SW R1 to address 0x102 (stores at 0x100); LW R2 from 0x100 → R2=0x12345678. With the byte-access macro defined, LB R3 from 0x101 → 0x00000034.
- Branch/jump:
  - BEQ R0,R0 to imm 0x40 → next `imem_addr=0x040`.
  - BNE R0,R0 → PC+4.
  - JAL R7,R0,0x80 at pc 0x40 → R7=0x44, PC=0x80.
- R0 and HALT: ADDI R0,R0,7 → R0 reads 0. HALT at 0x10 → `halted=1`, PC stays 0x10 for 20+ clocks, no further `retire`.
- Undefined opcode 0x3E → no register or memory change, PC+4.

Source files
------------

// File: rtl/mc_cpu32_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_cpu32_if
// Brief    : Instruction-fetch, status and debug-read bundle for mc_cpu32.
// Revision : 1.0
// ============================================================================
interface mc_cpu32_if #(
  parameter int PC_W = 12
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            halted;
  logic            retire;
  logic [3:0]      dbg_sel;
  logic [31:0]     dbg_data;

  modport master (
    output imem_addr, halted, retire, dbg_data,
    input  imem_rdata, dbg_sel
  );

  modport slave (
    input  imem_addr, halted, retire, dbg_data,
    output imem_rdata, dbg_sel
  );
endinterface
`default_nettype wire

// File: rtl/mc_cpu32.sv
`default_nettype none
// ============================================================================
// Module   : mc_cpu32
// Brief    : Six-state multicycle 32-bit core with 16x32 regfile and
//            big-endian byte-addressed data memory.
// Config   : MC_CPU32_BYTE_ACCESS_EN enables LB (0x21) and SB (0x23).
// Revision : 1.0
// ============================================================================
module mc_cpu32 #(
  parameter int PC_W    = 12,
  parameter int DMEM_AW = 12
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mc_cpu32_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_retire;

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_alu;
  logic [31:0]     r_mdr;
  logic            r_cond;
  logic            r_halted;
  logic [31:0]     r_regs [16];
  logic [7:0]      r_dmem [2**DMEM_AW];

  logic [5:0]      w_op;
  logic [3:0]      w_rd;
  logic [3:0]      w_rs1;
  logic [3:0]      w_rs2;
  logic [31:0]     w_imm;

  assign w_op  = r_ir[31:26];
  assign w_rd  = r_ir[25:22];
  assign w_rs1 = r_ir[21:18];
  assign w_rs2 = r_ir[17:14];
  assign w_imm = {{18{r_ir[13]}}, r_ir[13:0]};

  logic w_is_alu, w_is_lw, w_is_sw, w_is_lb, w_is_sb;
  logic w_is_beq, w_is_bne, w_is_jal, w_is_halt, w_wr_en;

  // ALU opcodes are 0x00-0x09 and their immediate twins 0x10-0x19
  assign w_is_alu  = (w_op[5] == 1'b0) && (w_op[3:0] <= 4'd9);
  assign w_is_lw   = (w_op == 6'h20);
  assign w_is_sw   = (w_op == 6'h22);
  assign w_is_beq  = (w_op == 6'h30);
  assign w_is_bne  = (w_op == 6'h31);
  assign w_is_jal  = (w_op == 6'h32);
  assign w_is_halt = (w_op == 6'h3F);
`ifdef MC_CPU32_BYTE_ACCESS_EN
  assign w_is_lb   = (w_op == 6'h21);
  assign w_is_sb   = (w_op == 6'h23);
`else
  assign w_is_lb   = 1'b0;
  assign w_is_sb   = 1'b0;
`endif
  assign w_wr_en   = w_is_alu | w_is_lw | w_is_lb | w_is_jal;

  logic [31:0] w_rs1_val, w_rs2_val;
  assign w_rs1_val = (w_rs1 == 4'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 4'd0) ? 32'd0 : r_regs[w_rs2];

  logic [31:0] w_opb, w_alu, w_agen;
  logic [4:0]  w_shamt;
  logic        w_cond;

  assign w_opb   = w_op[4] ? w_imm : r_b;
  assign w_shamt = w_opb[4:0];
  assign w_agen  = r_a + w_imm;
  assign w_cond  = w_is_beq ? (r_a == r_b) : (r_a != r_b);

  always_comb begin
    w_alu = r_a + w_opb;
    case (w_op[3:0])
      4'd0:    w_alu = r_a + w_opb;
      4'd1:    w_alu = r_a - w_opb;
      4'd2:    w_alu = r_a & w_opb;
      4'd3:    w_alu = r_a | w_opb;
      4'd4:    w_alu = r_a ^ w_opb;
      4'd5:    w_alu = r_a << w_shamt;
      4'd6:    w_alu = r_a >> w_shamt;
      4'd7:    w_alu = $signed(r_a) >>> w_shamt;
      4'd8:    w_alu = {31'd0, $signed(r_a) < $signed(w_opb)};
      4'd9:    w_alu = {31'd0, r_a < w_opb};
      default: w_alu = r_a + w_opb;
    endcase
  end

  logic [DMEM_AW-1:0] w_maddr;
  logic [DMEM_AW-3:0] w_mword;
  logic [31:0]        w_load_word;
  logic [7:0]         w_load_byte;

  assign w_maddr     = r_alu[DMEM_AW-1:0];
  assign w_mword     = w_maddr[DMEM_AW-1:2];
  assign w_load_word = {r_dmem[{w_mword, 2'b00}], r_dmem[{w_mword, 2'b01}],
                        r_dmem[{w_mword, 2'b10}], r_dmem[{w_mword, 2'b11}]};
  assign w_load_byte = r_dmem[w_maddr];

  logic [PC_W-1:0] w_pc_inc, w_pc_nxt;
  logic [31:0]     w_wb_data;

  assign w_pc_inc  = r_pc + {{(PC_W-3){1'b0}}, 3'd4};
  assign w_pc_nxt  = w_is_jal ? {r_alu[PC_W-1:2], 2'b00} :
                     ((w_is_beq | w_is_bne) & r_cond) ? {w_imm[PC_W-1:2], 2'b00} :
                     w_pc_inc;
  assign w_wb_data = w_is_jal ? 32'(w_pc_inc) : (w_is_alu ? r_alu : r_mdr);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_MEM;
      S_MEM:    w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_PC;
      S_PC: begin
        w_retire    = 1'b1;
        w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
      end
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_alu    <= '0;
      r_mdr    <= '0;
      r_cond   <= 1'b0;
      r_halted <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:  r_ir <= bus.imem_rdata;
        S_DECODE: begin
          r_a <= w_rs1_val;
          r_b <= w_rs2_val;
        end
        S_EXEC: begin
          r_alu  <= w_is_alu ? w_alu : w_agen;
          r_cond <= w_cond;
        end
        S_MEM: begin
          if (w_is_lw)      r_mdr <= w_load_word;
          else if (w_is_lb) r_mdr <= {{24{w_load_byte[7]}}, w_load_byte};
        end
        S_WB: begin
          if (w_wr_en && (w_rd != 4'd0)) r_regs[w_rd] <= w_wb_data;
        end
        S_PC: begin
          // HALT leaves the PC pointing at itself
          if (w_is_halt) r_halted <= 1'b1;
          else           r_pc     <= w_pc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Data memory has no reset; a reset cycle still suppresses the store
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_MEM)) begin
      if (w_is_sw) begin
        r_dmem[{w_mword, 2'b00}] <= r_b[31:24];
        r_dmem[{w_mword, 2'b01}] <= r_b[23:16];
        r_dmem[{w_mword, 2'b10}] <= r_b[15:8];
        r_dmem[{w_mword, 2'b11}] <= r_b[7:0];
      end
      if (w_is_sb) r_dmem[w_maddr] <= r_b[7:0];
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.retire    = w_retire;
  assign bus.halted    = r_halted | (w_retire & w_is_halt);
  assign bus.dbg_data  = r_regs[bus.dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu32.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_cpu32
// Brief    : Vector table, directed sequences and random programs for mc_cpu32.
// Revision : 1.0
// ============================================================================
module tb_mc_cpu32;

  localparam int PW = 12;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  mc_cpu32_if #(.PC_W(PW)) bus();

  mc_cpu32 #(.PC_W(PW), .DMEM_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] imem [1024];
  assign bus.imem_rdata = imem[bus.imem_addr[11:2]];

  int n_checks = 0;
  int n_errors = 0;
  int wp;
  int          ret_cyc [$];
  logic [11:0] ret_pc  [$];

  logic [31:0] m_regs [16];
  logic [7:0]  m_mem  [4096];
  logic [11:0] m_pc;
  int          m_retired;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [13:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [13:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [3:0] r, output logic [31:0] v);
    bus.dbg_sel = r;
    #1;
    v = bus.dbg_data;
  endtask

  task automatic new_prog();
    for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
    wp = 0;
  endtask

  task automatic put(input logic [31:0] w);
    imem[wp] = w;
    wp++;
  endtask

  task automatic load_const(input logic [3:0] r, input logic [31:0] v);
    put(enc(6'h13, r, 4'd0, 4'd0, {4'd0, v[31:22]}));
    put(enc(6'h15, r, r, 4'd0, 14'd11));
    put(enc(6'h13, r, r, 4'd0, {3'd0, v[21:11]}));
    put(enc(6'h15, r, r, 4'd0, 14'd11));
    put(enc(6'h13, r, r, 4'd0, {3'd0, v[10:0]}));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the call; records retire cycles and the PC that follows
  task automatic run_prog(input int max_cyc);
    int cyc;
    bit prev;
    cyc = 0;
    prev = 1'b0;
    ret_cyc.delete();
    ret_pc.delete();
    forever begin
      @(negedge clk);
      cyc++;
      if (prev) ret_pc.push_back(bus.imem_addr);
      prev = bus.retire;
      if (bus.retire) ret_cyc.push_back(cyc);
      if (bus.halted) break;
      if (cyc >= max_cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL run_timeout: got no halt after %0d cycles want halt", cyc);
        break;
      end
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
    if (r != 4'd0) m_regs[r] = v;
  endtask

  // Instruction-level interpreter over the same program image
  task automatic model_run();
    logic [31:0] ins, a, b, imm, ea;
    logic [5:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [11:0] nxt, wa, ba;
    logic [7:0]  byt;
    m_pc = '0;
    m_retired = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    for (int step = 0; step < 5000; step++) begin
      ins = imem[m_pc[11:2]];
      op  = ins[31:26];
      rd  = ins[25:22];
      rs1 = ins[21:18];
      rs2 = ins[17:14];
      imm = {{18{ins[13]}}, ins[13:0]};
      a   = m_regs[rs1];
      b   = m_regs[rs2];
      m_retired++;
      if (op == 6'h3F) return;
      nxt = m_pc + 12'd4;
      ea  = a + imm;
      ba  = ea[11:0];
      wa  = ba & 12'hFFC;
      if ((op <= 6'h09) || ((op >= 6'h10) && (op <= 6'h19)))
        set_reg(rd, ref_alu(op[3:0], a, (op >= 6'h10) ? imm : b));
      else begin
        case (op)
          6'h20: set_reg(rd, {m_mem[wa], m_mem[wa + 12'd1], m_mem[wa + 12'd2], m_mem[wa + 12'd3]});
          6'h22: begin
            m_mem[wa]          = b[31:24];
            m_mem[wa + 12'd1]  = b[23:16];
            m_mem[wa + 12'd2]  = b[15:8];
            m_mem[wa + 12'd3]  = b[7:0];
          end
`ifdef MC_CPU32_BYTE_ACCESS_EN
          6'h21: begin
            byt = m_mem[ba];
            set_reg(rd, {{24{byt[7]}}, byt});
          end
          6'h23: m_mem[ba] = b[7:0];
`endif
          6'h30: if (a == b) nxt = imm[11:0] & 12'hFFC;
          6'h31: if (a != b) nxt = imm[11:0] & 12'hFFC;
          6'h32: begin
            set_reg(rd, {20'd0, m_pc + 12'd4});
            nxt = ba & 12'hFFC;
          end
          default: ;
        endcase
      end
      m_pc = nxt;
    end
  endtask

  task automatic build_random();
    int          kind, t, halt_idx, w;
    logic [5:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [13:0] imm;
    logic [5:0]  undef_ops [6];
    undef_ops = '{6'h0A, 6'h1F, 6'h24, 6'h33, 6'h3E, 6'h2B};
    new_prog();
    for (int k = 0; k < 16; k++) put(enc(6'h22, 4'd0, 4'd0, 4'd0, 14'(512 + 4 * k)));
    halt_idx = 16 + 24;
    for (int i = 0; i < 24; i++) begin
      w    = 16 + i;
      kind = int'($urandom_range(0, 9));
      rd   = 4'($urandom_range(0, 15));
      rs1  = 4'($urandom_range(0, 15));
      rs2  = 4'($urandom_range(0, 15));
      imm  = 14'($urandom);
      op   = 6'h00;
      case (kind)
        0, 1, 2, 3: op = 6'(($urandom_range(0, 1) * 16) + $urandom_range(0, 9));
        4: begin op = 6'h22; rs1 = 4'd0; imm = 14'(512 + $urandom_range(0, 63)); end
        5: begin op = 6'h20; rs1 = 4'd0; imm = 14'(512 + $urandom_range(0, 63)); end
        6: begin
          op  = ($urandom_range(0, 1) == 1) ? 6'h21 : 6'h23;
          rs1 = 4'd0;
          imm = 14'(512 + $urandom_range(0, 63));
        end
        7: begin
          op  = ($urandom_range(0, 1) == 1) ? 6'h30 : 6'h31;
          t   = int'($urandom_range(w + 1, halt_idx));
          imm = 14'(t * 4);
        end
        8: begin
          op  = 6'h32;
          rs1 = 4'd0;
          t   = int'($urandom_range(w + 1, halt_idx));
          imm = 14'(t * 4);
        end
        default: op = undef_ops[$urandom_range(0, 5)];
      endcase
      put(enc(op, rd, rs1, rs2, imm));
    end
    put(HALT_W);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_r3, exp_r4;
    logic [11:0] exp_pcs [5];
    int bad_pc, bad_ret, bad_halt, bad_gap;

    bus.dbg_sel = 4'd0;

    vecs[0]  = '{6'h00, 32'hFFFF_FFFF, 32'h0000_0001, 14'h0000, 32'h0000_0000};
    vecs[1]  = '{6'h01, 32'h0000_0000, 32'h0000_0001, 14'h0000, 32'hFFFF_FFFF};
    vecs[2]  = '{6'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 14'h0000, 32'h00F0_00F0};
    vecs[3]  = '{6'h03, 32'hF000_0000, 32'h0000_000F, 14'h0000, 32'hF000_000F};
    vecs[4]  = '{6'h04, 32'hAAAA_5555, 32'hFFFF_0000, 14'h0000, 32'h5555_5555};
    vecs[5]  = '{6'h05, 32'h0000_0001, 32'h0000_0021, 14'h0000, 32'h0000_0002};
    vecs[6]  = '{6'h06, 32'h8000_0000, 32'h0000_001F, 14'h0000, 32'h0000_0001};
    vecs[7]  = '{6'h07, 32'h8000_0000, 32'h0000_0004, 14'h0000, 32'hF800_0000};
    vecs[8]  = '{6'h08, 32'hFFFF_FFFF, 32'h0000_0001, 14'h0000, 32'h0000_0001};
    vecs[9]  = '{6'h09, 32'hFFFF_FFFF, 32'h0000_0001, 14'h0000, 32'h0000_0000};
    vecs[10] = '{6'h10, 32'h0000_0005, 32'h0000_0000, 14'h3FFD, 32'h0000_0002};
    vecs[11] = '{6'h14, 32'h0000_FFFF, 32'h0000_0000, 14'h2000, 32'hFFFF_1FFF};
    vecs[12] = '{6'h17, 32'hFFFF_FF00, 32'h0000_0000, 14'h0004, 32'hFFFF_FFF0};
    vecs[13] = '{6'h18, 32'hFFFF_FFFE, 32'h0000_0000, 14'h3FFF, 32'h0000_0001};
    vecs[14] = '{6'h19, 32'h0000_0005, 32'h0000_0000, 14'h3FFF, 32'h0000_0001};
    vecs[15] = '{6'h15, 32'h0000_0003, 32'h0000_0000, 14'h3FE1, 32'h0000_0006};

    // ---- Reset mid-instruction, then the ALU sequence ----
    new_prog();
    put(enc(6'h10, 4'd1, 4'd0, 4'd0, 14'h3FFD));
    put(enc(6'h10, 4'd2, 4'd0, 4'd0, 14'd5));
    put(enc(6'h01, 4'd3, 4'd1, 4'd2, 14'd0));
    put(enc(6'h17, 4'd4, 4'd1, 4'd0, 14'd1));
    put(enc(6'h09, 4'd5, 4'd1, 4'd2, 14'd0));
    put(HALT_W);
    do_reset(2);
    repeat (15) @(negedge clk);
    rd_reg(4'd1, v); chk("pre_reset_r1", v, 32'hFFFF_FFFD);
    rd_reg(4'd2, v); chk("pre_reset_r2", v, 32'h0000_0005);
    do_reset(2);
    chk("reset_pc", 32'(bus.imem_addr), 32'h0);
    chk("reset_halted", 32'(bus.halted), 32'h0);
    chk("reset_retire", 32'(bus.retire), 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'(i), v);
      chk($sformatf("reset_r%0d", i), v, 32'h0);
    end
    run_prog(200);
    // retire is high through the sixth clock after release (cycle index 5 here)
    chk("first_retire_cycle", (ret_cyc.size() > 0) ? 32'(ret_cyc[0]) : 32'hFFFF_FFFF, 32'd5);
    chk("alu_retire_count", 32'(ret_cyc.size()), 32'd6);
    for (int i = 1; i < ret_cyc.size(); i++)
      chk($sformatf("alu_retire_gap%0d", i), 32'(ret_cyc[i] - ret_cyc[i-1]), 32'd6);
    rd_reg(4'd3, v); chk("alu_sub_r3", v, 32'hFFFF_FFF8);
    rd_reg(4'd4, v); chk("alu_srai_r4", v, 32'hFFFF_FFFE);
    rd_reg(4'd5, v); chk("alu_sltu_r5", v, 32'h0000_0000);

    // ---- ALU vector table ----
    for (int i = 0; i < 16; i++) begin
      new_prog();
      load_const(4'd1, vecs[i].a);
      load_const(4'd2, vecs[i].b);
      put(enc(vecs[i].op, 4'd3, 4'd1, 4'd2, vecs[i].imm));
      put(HALT_W);
      do_reset(2);
      run_prog(500);
      rd_reg(4'd3, v);
      chk($sformatf("vec%0d_op%02h", i, vecs[i].op), v, vecs[i].exp);
    end

    // ---- Memory: word store/load, big-endian bytes ----
    new_prog();
    load_const(4'd1, 32'h1234_5678);
    put(enc(6'h22, 4'd0, 4'd0, 4'd1, 14'h102));
    put(enc(6'h20, 4'd2, 4'd0, 4'd0, 14'h100));
    put(enc(6'h21, 4'd3, 4'd0, 4'd0, 14'h101));
    put(enc(6'h23, 4'd0, 4'd0, 4'd1, 14'h100));
    put(enc(6'h20, 4'd4, 4'd0, 4'd0, 14'h100));
    put(HALT_W);
    do_reset(2);
    run_prog(500);
`ifdef MC_CPU32_BYTE_ACCESS_EN
    exp_r3 = 32'h0000_0034;
    exp_r4 = 32'h7834_5678;
`else
    exp_r3 = 32'h0000_0000;
    exp_r4 = 32'h1234_5678;
`endif
    rd_reg(4'd2, v); chk("mem_lw_r2", v, 32'h1234_5678);
    rd_reg(4'd3, v); chk("mem_lb_r3", v, exp_r3);
    rd_reg(4'd4, v); chk("mem_sb_lw_r4", v, exp_r4);

    // ---- Branch / jump ----
    new_prog();
    imem[0]     = enc(6'h31, 4'd0, 4'd0, 4'd0, 14'h020);
    imem[1]     = enc(6'h30, 4'd0, 4'd0, 4'd0, 14'h040);
    imem[16]    = enc(6'h32, 4'd7, 4'd0, 4'd0, 14'h080);
    imem[32]    = enc(6'h10, 4'd9, 4'd0, 4'd0, 14'h0C0);
    imem[33]    = enc(6'h32, 4'd9, 4'd9, 4'd0, 14'h004);
    exp_pcs     = '{12'h004, 12'h040, 12'h080, 12'h084, 12'h0C4};
    do_reset(2);
    run_prog(500);
    chk("br_step_count", 32'(ret_pc.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("br_pc%0d", i), (i < ret_pc.size()) ? 32'(ret_pc[i]) : 32'hFFFF_FFFF,
          32'(exp_pcs[i]));
    rd_reg(4'd7, v); chk("jal_link_r7", v, 32'h0000_0044);
    rd_reg(4'd9, v); chk("jal_self_r9", v, 32'h0000_0088);
    chk("br_halt_pc", 32'(bus.imem_addr), 32'h0C4);

    // ---- R0 discard, undefined opcode, HALT freeze ----
    new_prog();
    put(enc(6'h10, 4'd0, 4'd0, 4'd0, 14'd7));
    put(enc(6'h3E, 4'd1, 4'd0, 4'd0, 14'd5));
    put(enc(6'h10, 4'd2, 4'd0, 4'd0, 14'd9));
    put(enc(6'h3E, 4'd2, 4'd2, 4'd2, 14'h3FFF));
    put(HALT_W);
    do_reset(2);
    run_prog(500);
    chk("halt_retire_count", 32'(ret_cyc.size()), 32'd5);
    chk("halt_pc", 32'(bus.imem_addr), 32'h010);
    rd_reg(4'd0, v); chk("r0_reads_zero", v, 32'h0);
    rd_reg(4'd1, v); chk("undef_no_write_r1", v, 32'h0);
    rd_reg(4'd2, v); chk("undef_keeps_r2", v, 32'h9);
    bad_pc = 0; bad_ret = 0; bad_halt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.imem_addr != 12'h010) bad_pc++;
      if (bus.retire) bad_ret++;
      if (!bus.halted) bad_halt++;
    end
    chk("halt_pc_frozen", 32'(bad_pc), 32'd0);
    chk("halt_no_retire", 32'(bad_ret), 32'd0);
    chk("halt_sticky", 32'(bad_halt), 32'd0);

    // ---- Random programs against the reference interpreter ----
    for (int p = 0; p < 6; p++) begin
      build_random();
      model_run();
      do_reset(2);
      run_prog(3000);
      chk($sformatf("rnd%0d_retired", p), 32'(ret_cyc.size()), 32'(m_retired));
      chk($sformatf("rnd%0d_pc", p), 32'(bus.imem_addr), 32'(m_pc));
      bad_gap = 0;
      for (int i = 1; i < ret_cyc.size(); i++)
        if (ret_cyc[i] - ret_cyc[i-1] != 6) bad_gap++;
      chk($sformatf("rnd%0d_gaps", p), 32'(bad_gap), 32'd0);
      for (int i = 0; i < 16; i++) begin
        rd_reg(4'(i), v);
        chk($sformatf("rnd%0d_r%0d", p, i), v, m_regs[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
